// File: rtl/logic_gate_pipe.sv
// ---------------------------------------------------------------------------
// logic_gate_pipe
//
// WIDTH-bit bitwise logic unit with a run-time selectable operation, wrapped
// in a STAGES-deep valid/ready pipeline with full backpressure and a count of
// completed output transfers.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. A producer holding valid may not assume the beat
// moved until it sees ready high at that edge. Ready never depends on valid,
// so there are no combinational valid->ready loops.
//
// Parameters
//   WIDTH   operand / result width in bits (>= 1)
//   STAGES  number of pipeline register stages = latency in cycles (>= 1)
//   CNT_W   width of the completed-transfer counter
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands / opcode valid
//   in_ready   out  1      unit can accept a beat this cycle
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_op      in   3      opcode:
//                            000 A&B   001 A|B   010 A^B    011 ~(A&B)
//                            100 ~(A|B) 101 ~(A^B) 110 A     111 ~A
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts
//   out_data   out  WIDTH  result
//   xfer_cnt   out  CNT_W  completed output transfers, wraps modulo 2^CNT_W
//
// Optional build macro LOGIC_GATE_PIPE_REDUCE_EN
//   When defined, three more outputs carry the AND / OR / XOR reduction of
//   the result. They are computed before stage 1 and travel through the pipe
//   alongside out_data, so they always line up with the result they describe.
//     out_red_and  out  1
//     out_red_or   out  1
//     out_red_xor  out  1
//   When undefined, those ports and their pipeline bits do not exist.
// ---------------------------------------------------------------------------
module logic_gate_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] xfer_cnt
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
   ,
   output logic             out_red_and,
   output logic             out_red_or,
   output logic             out_red_xor
`endif
);

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NAND = 3'b011,
      OP_NOR  = 3'b100,
      OP_XNOR = 3'b101,
      OP_PASS = 3'b110,
      OP_NOT  = 3'b111
   } op_e;

   // Payload carried by each stage: the result, plus the reduction bits
   // when that option is built in. Layout: [WIDTH]=and, [WIDTH+1]=or,
   // [WIDTH+2]=xor above the result bits.
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
   localparam int PW = WIDTH + 3;
`else
   localparam int PW = WIDTH;
`endif

   logic [WIDTH-1:0] op_result;
   logic [PW-1:0]    in_payload;

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] load;
   logic [PW-1:0]     stage_q [STAGES];

   // ------------------------------------------------------------------------
   // Operation decode, evaluated on the incoming operands.
   // ------------------------------------------------------------------------
   always_comb begin
      op_result = '0;
      case (op_e'(in_op))
         OP_AND:  op_result = in_a & in_b;
         OP_OR:   op_result = in_a | in_b;
         OP_XOR:  op_result = in_a ^ in_b;
         OP_NAND: op_result = ~(in_a & in_b);
         OP_NOR:  op_result = ~(in_a | in_b);
         OP_XNOR: op_result = ~(in_a ^ in_b);
         OP_PASS: op_result = in_a;
         OP_NOT:  op_result = ~in_a;
         default: op_result = '0;
      endcase
   end

`ifdef LOGIC_GATE_PIPE_REDUCE_EN
   assign in_payload = {^op_result, |op_result, &op_result, op_result};
`else
   assign in_payload = op_result;
`endif

   // ------------------------------------------------------------------------
   // Stage load enables.
   // Stage i may load when it is empty or when the stage after it loads; the
   // last stage loads when it is empty or the output is being taken. Unrolled,
   // that is: stage i is blocked only if it and every stage downstream of it
   // are full and the output is stalled. Writing it in that closed form keeps
   // each enable a function of the valid bits alone (no chained comb logic).
   // Empty stages always load, so bubbles collapse toward the output.
   // ------------------------------------------------------------------------
   for (genvar g = 0; g < STAGES; g++) begin : g_load
      assign load[g] = ~(&v_q[STAGES-1:g]) | out_ready;
   end

   assign in_ready = load[0];

   // ------------------------------------------------------------------------
   // Pipeline registers.
   // Valid bits shift on load. Data only changes when a valid beat moves in,
   // so a stage that takes a bubble keeps its old contents and out_data stays
   // put while stalled.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         if (load[0]) begin
            v_q[0] <= in_valid;
            if (in_valid) begin
               stage_q[0] <= in_payload;
            end
         end
         for (int i = 1; i < STAGES; i++) begin
            if (load[i]) begin
               v_q[i] <= v_q[i-1];
               if (v_q[i-1]) begin
                  stage_q[i] <= stage_q[i-1];
               end
            end
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign out_data  = stage_q[STAGES-1][WIDTH-1:0];

`ifdef LOGIC_GATE_PIPE_REDUCE_EN
   assign out_red_and = stage_q[STAGES-1][WIDTH];
   assign out_red_or  = stage_q[STAGES-1][WIDTH+1];
   assign out_red_xor = stage_q[STAGES-1][WIDTH+2];
`endif

   // ------------------------------------------------------------------------
   // Completed-transfer counter; wraps naturally at 2^CNT_W.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (out_valid && out_ready) begin
         xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_gate_pipe
//
// Bench for logic_gate_pipe. Expected results come from a per-bit truth
// table lookup and a popcount for the reduction bits; the scoreboard keeps
// accepted beats in arrival order and retires one per output transfer.
// ---------------------------------------------------------------------------
module tb_logic_gate_pipe;

   localparam int WIDTH  = 8;
   localparam int STAGES = 2;
   localparam int CNT_W  = 4;

`ifdef LOGIC_GATE_PIPE_REDUCE_EN
   localparam int EW = WIDTH + 3;
`else
   localparam int EW = WIDTH;
`endif

   // Truth table per opcode, indexed by {a_bit, b_bit}.
   localparam logic [3:0] TT [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                                     4'b0001, 4'b1001, 4'b1100, 4'b0011};
   localparam logic [7:0] SWEEP [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F,
                                        8'h03, 8'hC3, 8'hF0, 8'h0F};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic [2:0]       in_op = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] xfer_cnt;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
   logic out_red_and, out_red_or, out_red_xor;
`endif

   logic_gate_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .xfer_cnt  (xfer_cnt)
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
      ,
      .out_red_and (out_red_and),
      .out_red_or  (out_red_or),
      .out_red_xor (out_red_xor)
`endif
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0]    exp_q[$];
   int               stamp_q[$];
   logic [EW-1:0]    obs_log[$];
   int               obs_cyc[$];
   int               exp_cnt = 0;
   int               cyc = 0;
   bit               lat_mode = 1'b0;
   bit               hold_valid = 1'b0;
   logic [WIDTH-1:0] hold_data = '0;
   int               n_checks = 0;
   int               n_fail = 0;

   always @(posedge clk) cyc++;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [EW-1:0] model(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      logic [EW-1:0]    e;
      int               ones;
      ones = 0;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = TT[op][{a[i], b[i]}];
         ones += int'(r[i]);
      end
      e = '0;
      e[WIDTH-1:0] = r;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
      e[WIDTH]   = (ones == WIDTH);
      e[WIDTH+1] = (ones != 0);
      e[WIDTH+2] = ones[0];
`endif
      return e;
   endfunction

   function automatic logic [EW-1:0] observed();
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
      return {out_red_xor, out_red_or, out_red_and, out_data};
`else
      return out_data;
`endif
   endfunction

   // ---------------- monitor (samples on falling edge) ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         check_eq("in_ready", in_ready, (exp_q.size() < STAGES) || out_ready);
         if (hold_valid) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_data", out_data, hold_data);
         end
         hold_valid = out_valid && !out_ready;
         hold_data  = out_data;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_out", out_valid, 0);
            end else begin
               logic [EW-1:0] e;
               int t;
               e = exp_q.pop_front();
               t = stamp_q.pop_front();
               check_eq("out_payload", observed(), e);
               if (t >= 0) check_eq("latency", cyc - t, STAGES);
            end
            check_eq("xfer_cnt", xfer_cnt, exp_cnt);
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            obs_log.push_back(observed());
            obs_cyc.push_back(cyc);
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_op, in_a, in_b));
            stamp_q.push_back(lat_mode ? cyc : -1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset(input string tag);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_eq({tag, "_out_valid"}, out_valid, 0);
      check_eq({tag, "_out_data"}, out_data, 0);
      check_eq({tag, "_xfer_cnt"}, xfer_cnt, 0);
      check_eq({tag, "_in_ready"}, in_ready, 1);
      exp_q.delete();
      stamp_q.delete();
      obs_log.delete();
      obs_cyc.delete();
      exp_cnt    = 0;
      hold_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted (called at posedge + 1).
   task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
      int  guard;
      bit  acc;
      guard    = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!acc && guard < 200);
      if (!acc) check_eq("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard     = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      @(posedge clk);
      #1;
      check_eq("drain_empty", exp_q.size(), 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      apply_reset("init");

      // Opcode sweep with out_ready held high.
      out_ready = 1'b1;
      lat_mode  = 1'b1;
      for (int op = 0; op < 8; op++) send(3'(op), 8'hF0, 8'hCC);
      drain();
      check_eq("sweep_count", obs_log.size(), 8);
      for (int i = 0; i < 8 && i < obs_log.size(); i++)
         check_eq($sformatf("sweep_op%0d", i), obs_log[i][WIDTH-1:0], SWEEP[i]);
      lat_mode = 1'b0;

      // Streaming: 16 back-to-back beats.
      apply_reset("rst_stream");
      out_ready = 1'b1;
      lat_mode  = 1'b1;
      for (int i = 0; i < 16; i++)
         send(3'($urandom_range(0, 7)), WIDTH'($urandom()), WIDTH'($urandom()));
      drain();
      lat_mode = 1'b0;
      check_eq("stream_count", obs_log.size(), 16);
      for (int i = 1; i < obs_cyc.size(); i++)
         check_eq($sformatf("stream_gap%0d", i), obs_cyc[i] - obs_cyc[i-1], 1);
      check_eq("stream_xfer_cnt", xfer_cnt, 16 % (1 << CNT_W));

      // Backpressure: fill, stall for 5 cycles with a third beat waiting.
      apply_reset("rst_bp");
      out_ready = 1'b0;
      send(3'd2, 8'hA5, 8'h0F);
      send(3'd7, 8'h3C, 8'h00);
      in_valid = 1'b1;
      in_op    = 3'd1;
      in_a     = 8'h11;
      in_b     = 8'h80;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_out_valid", out_valid, 1);
      out_ready = 1'b1;
      send(3'd1, 8'h11, 8'h80);
      drain();
      check_eq("bp_count", obs_log.size(), 3);

      // Random traffic with random backpressure.
      apply_reset("rst_rand");
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_op     = 3'($urandom_range(0, 7));
         in_a      = WIDTH'($urandom());
         in_b      = WIDTH'($urandom());
         out_ready = ($urandom_range(0, 9) < 6);
         @(posedge clk);
         #1;
      end
      drain();

      // Reset with two results in flight.
      out_ready = 1'b0;
      send(3'd0, 8'hFF, 8'h0F);
      send(3'd3, 8'h12, 8'h34);
      check_eq("mid_pre_valid", out_valid, 1);
      #2;
      apply_reset("mid_rst");
      out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check_eq("post_rst_idle", out_valid, 0);
      end
      @(posedge clk);
      #1;

      // Counter wrap: 17 transfers with a 4-bit counter.
      apply_reset("rst_wrap");
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++)
         send(3'($urandom_range(0, 7)), WIDTH'($urandom()), WIDTH'($urandom()));
      drain();
      check_eq("wrap_xfer_cnt", xfer_cnt, 1);

`ifdef LOGIC_GATE_PIPE_REDUCE_EN
      // Reduction outputs aligned with their results.
      apply_reset("rst_red");
      out_ready = 1'b1;
      send(3'd0, 8'hFF, 8'hFF);
      send(3'd0, 8'h01, 8'h01);
      drain();
      check_eq("red_count", obs_log.size(), 2);
      if (obs_log.size() == 2) begin
         check_eq("red0_data", obs_log[0][WIDTH-1:0], 8'hFF);
         check_eq("red0_bits", obs_log[0][WIDTH+:3], 3'b011);
         check_eq("red1_data", obs_log[1][WIDTH-1:0], 8'h01);
         check_eq("red1_bits", obs_log[1][WIDTH+:3], 3'b110);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
